// File: rtl/handshake_skid_buffer_if.sv
// Ready/valid stream bundle between a producer, the skid buffer and a consumer.
// The slave modport is the buffer's view; master is the environment's view.
interface handshake_skid_buffer_if #(
  parameter int unsigned WORD_WIDTH = 8
);
  logic                  up_valid;
  logic [WORD_WIDTH-1:0] up_data;
  logic                  up_ready;
  logic                  down_valid;
  logic [WORD_WIDTH-1:0] down_data;
  logic                  down_ready;
  logic                  my_accept;
  logic                  my_transmit;

  modport slave (
    input  up_valid, up_data, down_ready,
    output up_ready, down_valid, down_data, my_accept, my_transmit
  );

  modport master (
    output up_valid, up_data, down_ready,
    input  up_ready, down_valid, down_data, my_accept, my_transmit
  );
endinterface

// File: rtl/handshake_skid_buffer.sv
// Two-entry skid buffer: registered up_ready/down_valid/down_data, full
// throughput, one word of slack while downstream stalls.
module handshake_skid_buffer #(
  parameter int unsigned WORD_WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  handshake_skid_buffer_if.slave  bus
);

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_BUSY  = 2'd1;
  localparam logic [1:0] ST_FULL  = 2'd2;

  logic [1:0]            state_q, state_d;
  logic [WORD_WIDTH-1:0] out_q, out_d;
  logic [WORD_WIDTH-1:0] skid_q, skid_d;
  logic                  up_ready_q, up_ready_d;
  logic                  down_valid_q, down_valid_d;
  logic                  accept;
  logic                  transmit;

  assign accept   = bus.up_valid & up_ready_q;
  assign transmit = down_valid_q & bus.down_ready;

  assign bus.up_ready    = up_ready_q;
  assign bus.down_valid  = down_valid_q;
  assign bus.down_data   = out_q;
  assign bus.my_accept   = accept;
  assign bus.my_transmit = transmit;

  // Next state and storage moves; ready/valid flops are decoded from the
  // next state so both stay registered with no input-to-output path.
  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    skid_d  = skid_q;
    case (state_q)
      ST_EMPTY: begin
        if (accept) begin
          out_d   = bus.up_data;
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (accept && !transmit) begin
          skid_d  = bus.up_data;
          state_d = ST_FULL;
        end else if (accept && transmit) begin
          out_d   = bus.up_data;
        end else if (!accept && transmit) begin
          state_d = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (transmit) begin
          out_d   = skid_q;
          state_d = ST_BUSY;
        end
      end
      default: begin
        state_d = ST_EMPTY;
      end
    endcase
    up_ready_d   = (state_d != ST_FULL);
    down_valid_d = (state_d != ST_EMPTY);
  end

  // State and data registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_EMPTY;
      out_q        <= '0;
      skid_q       <= '0;
      up_ready_q   <= 1'b0;
      down_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      out_q        <= out_d;
      skid_q       <= skid_d;
      up_ready_q   <= up_ready_d;
      down_valid_q <= down_valid_d;
    end
  end

endmodule

// File: tb/tb_handshake_skid_buffer.sv
// Directed bench for handshake_skid_buffer with hand-computed expectations.
module tb_handshake_skid_buffer;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;

  handshake_skid_buffer_if #(.WORD_WIDTH(8)) bus ();

  handshake_skid_buffer #(.WORD_WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // advance past the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  logic [7:0] words [12];
  int in_idx, out_idx, acc_cnt, tx_cnt, cyc;

  initial begin
    errors = 0;
    checks = 0;
    rst_n = 1'b0;
    bus.up_valid = 1'b1;
    bus.up_data = 8'h5A;
    bus.down_ready = 1'b0;

    // reset
    tick();
    tick();
    check("rst_up_ready", bus.up_ready, 0);
    check("rst_down_valid", bus.down_valid, 0);
    check("rst_down_data", bus.down_data, 8'h00);
    check("rst_accept", bus.my_accept, 0);
    rst_n = 1'b1;
    tick();
    check("post_rst_up_ready", bus.up_ready, 1);
    check("post_rst_down_valid", bus.down_valid, 0);
    bus.up_valid = 1'b0;
    settle();
    tick();

    // pass-through
    bus.down_ready = 1'b1;
    bus.up_valid = 1'b1;
    bus.up_data = 8'hA5;
    settle();
    check("pt_accept0", bus.my_accept, 1);
    tick();
    check("pt_data0", bus.down_data, 8'hA5);
    check("pt_valid0", bus.down_valid, 1);
    check("pt_ready0", bus.up_ready, 1);
    bus.up_data = 8'h3C;
    settle();
    check("pt_tx0", bus.my_transmit, 1);
    check("pt_accept1", bus.my_accept, 1);
    tick();
    check("pt_data1", bus.down_data, 8'h3C);
    check("pt_ready1", bus.up_ready, 1);
    bus.up_valid = 1'b0;
    settle();
    check("pt_tx1", bus.my_transmit, 1);
    tick();
    check("pt_drained", bus.down_valid, 0);

    // backpressure
    bus.down_ready = 1'b0;
    bus.up_valid = 1'b1;
    bus.up_data = 8'h11;
    tick();
    check("bp_data11", bus.down_data, 8'h11);
    check("bp_ready_busy", bus.up_ready, 1);
    bus.up_data = 8'h22;
    tick();
    check("bp_ready_full", bus.up_ready, 0);
    check("bp_hold11_a", bus.down_data, 8'h11);
    bus.up_data = 8'h33;
    settle();
    check("bp_no_accept", bus.my_accept, 0);
    tick();
    check("bp_hold11_b", bus.down_data, 8'h11);
    check("bp_still_full", bus.up_ready, 0);
    bus.down_ready = 1'b1;
    settle();
    check("bp_tx11", bus.my_transmit, 1);
    check("bp_no_accept2", bus.my_accept, 0);
    tick();
    check("bp_data22", bus.down_data, 8'h22);
    check("bp_ready_back", bus.up_ready, 1);
    settle();
    check("bp_accept33", bus.my_accept, 1);
    tick();
    check("bp_data33", bus.down_data, 8'h33);
    bus.up_valid = 1'b0;
    tick();
    check("bp_drained", bus.down_valid, 0);

    // simultaneous accept and transmit in BUSY
    bus.down_ready = 1'b0;
    bus.up_valid = 1'b1;
    bus.up_data = 8'h40;
    tick();
    check("sim_data40", bus.down_data, 8'h40);
    bus.up_data = 8'h41;
    bus.down_ready = 1'b1;
    settle();
    check("sim_accept", bus.my_accept, 1);
    check("sim_tx", bus.my_transmit, 1);
    tick();
    check("sim_data41", bus.down_data, 8'h41);
    check("sim_valid", bus.down_valid, 1);
    check("sim_busy_ready", bus.up_ready, 1);
    bus.up_valid = 1'b0;
    tick();
    check("sim_drained", bus.down_valid, 0);

    // alternating ready with 12 random words
    foreach (words[i]) words[i] = 8'($urandom_range(0, 255));
    in_idx = 0; out_idx = 0; acc_cnt = 0; tx_cnt = 0; cyc = 0;
    while (out_idx < 12 && cyc < 200) begin
      bus.down_ready = cyc[0];
      bus.up_valid = (in_idx < 12);
      bus.up_data = (in_idx < 12) ? words[in_idx] : 8'h00;
      settle();
      if (bus.my_transmit) begin
        check("alt_order", bus.down_data, words[out_idx]);
        out_idx++;
        tx_cnt++;
      end
      if (bus.my_accept) begin
        in_idx++;
        acc_cnt++;
      end
      tick();
      cyc++;
    end
    check("alt_timeout", out_idx, 12);
    check("alt_accepts", acc_cnt, 12);
    check("alt_transmits", tx_cnt, 12);
    bus.up_valid = 1'b0;
    bus.down_ready = 1'b0;
    settle();
    check("alt_empty", bus.down_valid, 0);

    // reset while FULL
    bus.up_valid = 1'b1;
    bus.up_data = 8'h11;
    tick();
    bus.up_data = 8'h22;
    tick();
    bus.up_valid = 1'b0;
    check("rf_full", bus.up_ready, 0);
    rst_n = 1'b0;
    tick();
    check("rf_down_valid", bus.down_valid, 0);
    check("rf_up_ready", bus.up_ready, 0);
    rst_n = 1'b1;
    bus.down_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      settle();
      check("rf_no_tx", bus.my_transmit, 0);
      tick();
    end
    check("rf_ready_back", bus.up_ready, 1);
    check("rf_valid_low", bus.down_valid, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/handshake_skid_buffer.md
# handshake_skid_buffer

Two-entry skid buffer on a ready/valid (valid-ready) stream. It sits between an upstream producer and a downstream consumer and breaks every combinational path between them: `up_ready`, `down_valid` and `down_data` are all registered. It sustains one word per cycle and absorbs one extra word when downstream stalls. It also exports per-cycle accept and transmit strobes for monitoring and scoreboarding.

## Interface
- `WORD_WIDTH`, default 8: width of the data word.

- `clk`  in  1  sole clock; all state changes on the rising edge.
- `rst_n`  in  1  reset, synchronous and active-low.
- `up_valid`  in  1  upstream word on `up_data` is valid.
- `up_data`  in  WORD_WIDTH  upstream word.
- `up_ready`  out  1  buffer can take a word this cycle (registered).
- `down_valid`  out  1  `down_data` holds a valid word (registered).
- `down_data`  out  WORD_WIDTH  downstream word (registered).
- `down_ready`  in  1  downstream takes the word this cycle.
- `my_accept`  out  1  combinational `up_valid & up_ready`, meaning an upstream word is taken this edge.
- `my_transmit`  out  1  combinational `down_valid & down_ready`, meaning a downstream word leaves this edge.

## Operation
- **Storage:** output register (OUT) drives `down_data`; a skid register (SKID) holds the second word. Capacity is 2 words, strictly FIFO order, with no loss or duplication.
- **States:**
  - EMPTY: `up_ready`=1, `down_valid`=0.
  - BUSY: OUT valid, SKID empty; `up_ready`=1, `down_valid`=1.
  - FULL: OUT and SKID valid; `up_ready`=0, `down_valid`=1.
- **Transitions** (A = `my_accept`, T = `my_transmit`):
  - EMPTY, A: OUT<=`up_data`, go to BUSY. Otherwise stay in EMPTY.
  - BUSY, A&!T: SKID<=`up_data`, go to FULL.
  - BUSY, A&T: OUT<=`up_data`, stay in BUSY.
  - BUSY, !A&T: go to EMPTY.
  - BUSY, !A&!T: hold.
  - FULL, T: OUT<=SKID, go to BUSY. Otherwise hold; A cannot occur because `up_ready`=0.
- **Held word:** while `down_valid`=1 and `down_ready`=0, `down_data` is stable.
- **Upstream hold:** upstream must keep `up_valid` and `up_data` stable until accepted. The buffer does not depend on this for correctness. It samples `up_data` only on A.
- **Reset values** (edge with `rst_n`=0): state EMPTY, `down_valid`=0, `down_data`=0, SKID=0, `up_ready`=0.
  - In EMPTY, `up_ready` loads 1 on every edge. It therefore rises on the first edge with `rst_n`=1.
  - `my_accept` is 0 throughout reset.
- **Reset during operation:** all contents are discarded, including from BUSY or FULL. No word appears at the output after reset.
- **Width:** data passes unmodified; no arithmetic.

## Timing
- **Latency:** a word accepted at edge N is on `down_data` with `down_valid`=1 after edge N, when the buffer was EMPTY. Otherwise it follows the words ahead of it.
- **Throughput:** one word per cycle when `down_ready`=1 continuously. `up_ready` stays 1 in that case.
- **Backpressure:**
  - `up_ready` drops to 0 one cycle after the second word is accepted while OUT is stalled.
  - It returns to 1 the cycle after the first transmit from FULL.
- **Combinational paths:** none from any input to `up_ready`, `down_valid` or `down_data`. The only combinational outputs are `my_accept` and `my_transmit`.
- **Simultaneous accept and transmit in BUSY:** the new word replaces OUT at that edge; occupancy is unchanged.

## Test plan
- **Reset:** `rst_n`=0 for 2 cycles with `up_valid`=1, `up_data`=0x5A.
  - During reset: `up_ready`=0, `down_valid`=0, `down_data`=0x00, `my_accept`=0.
  - After the first edge with `rst_n`=1: `up_ready`=1.
- **Pass-through:** `down_ready`=1; 0xA5, 0x3C offered on consecutive cycles.
  - `down_data` shows 0xA5, then 0x3C, one cycle behind each accept.
  - `up_ready` stays 1; `my_transmit` pulses twice.
- **Backpressure:** `down_ready`=0; 0x11, 0x22, 0x33 offered back-to-back.
  - 0x11 and 0x22 are accepted; `up_ready`=0; 0x33 waits; `down_data`=0x11 stays stable.
  - Raise `down_ready`=1: output sequence is 0x11, 0x22, 0x33.
- **Alternating ready:** `down_ready` toggles every cycle; upstream sends 12 random words.
  - Output order matches input order.
  - Total `my_accept` count equals total `my_transmit` count (12) after drain.
- **Reset during FULL:** enter FULL holding 0x11, 0x22, then pulse `rst_n`=0 for one cycle.
  - `down_valid`=0 and `up_ready`=0 after that edge.
  - Neither 0x11 nor 0x22 is ever transmitted afterwards.
- **Simultaneous accept and transmit:** in BUSY holding 0x40, `up_valid`=1 with 0x41 and `down_ready`=1 in the same cycle.
  - State stays BUSY and `down_data`=0x41 next cycle.
